// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush scheduler: FSM state codes and
// the per-stage control bundle whose field order the pipeline top relies on.
package pipeline_stall_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MDU_BUSY = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                         ex_mem_we: 1'b0, mem_wb_we: 1'b0, if_id_flush: 1'b1,
                                         id_ex_flush: 1'b1, ex_mem_flush: 1'b1};
  localparam stage_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                          ex_mem_we: 1'b0, mem_wb_we: 1'b0, if_id_flush: 1'b0,
                                          id_ex_flush: 1'b0, ex_mem_flush: 1'b0};
  // MDU holds EX: younger stages hold, a bubble drains forward into EX/MEM.
  localparam stage_ctrl_t CTRL_MDU = '{pc_write: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                       ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_flush: 1'b1};
  localparam stage_ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                            ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_id_flush: 1'b1,
                                            id_ex_flush: 1'b1, ex_mem_flush: 1'b0};
  localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b1,
                                            ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_id_flush: 1'b0,
                                            id_ex_flush: 1'b1, ex_mem_flush: 1'b0};
  localparam stage_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                       ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the stall scheduler (slave).
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load_use;
  logic             redirect;
  logic             mdu_start;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mdu_done;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output load_use, redirect, mdu_start, mem_req, mem_ready,
    input  pc_write, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush,
           mdu_done, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  load_use, redirect, mdu_start, mem_req, mem_ready,
    output pc_write, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush,
           mdu_done, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_stall_ctrl_perf_counter.sv
// Free-running event counter: synchronous clear, increments on inc, wraps modulo 2^CNT_W.
module pipeline_stall_ctrl_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: merges memory wait, MDU busy,
// redirect and load-use into per-stage enables/flushes, plus perf counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT     = 34,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int unsigned MDU_CNT_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam int unsigned WAIT_W    = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]           state_q, state_d;
  logic [MDU_CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 mem_stall_c;
  logic                 mdu_stall_c;
  logic                 redirect_ok_c;
  logic                 redirect_taken_c;
  logic                 mdu_done_c;
  stage_ctrl_t          ctrl_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      mdu_cnt_q  <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdu_cnt_q  <= mdu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // An MDU op frozen in EX by a memory wait keeps mdu_start high, so it starts on release.
  always_comb begin
    mem_stall_c   = bus.mem_req & ~bus.mem_ready;
    mdu_stall_c   = (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && bus.mdu_start)
                  || ((state_q == ST_MDU_BUSY) && (mdu_cnt_q != '0));
    redirect_ok_c = bus.redirect && (state_q != ST_MDU_BUSY);
  end

  always_comb begin
    state_d          = state_q;
    mdu_cnt_d        = mdu_cnt_q;
    wait_cnt_d       = '0;
    timeout_d        = timeout_q;
    ctrl_c           = CTRL_RUN;
    mdu_done_c       = 1'b0;
    redirect_taken_c = 1'b0;

    if (mem_stall_c) begin
      ctrl_c     = CTRL_FREEZE;
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                        : wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
        timeout_d = 1'b1;
      end
      if (state_q == ST_RUN) begin
        state_d = ST_MEM_WAIT;
      end
    end else if (mdu_stall_c) begin
      ctrl_c = CTRL_MDU;
      if (state_q == ST_MDU_BUSY) begin
        mdu_cnt_d = mdu_cnt_q - MDU_CNT_W'(1);
      end else begin
        state_d   = ST_MDU_BUSY;
        mdu_cnt_d = MDU_CNT_W'(MDU_LAT - 2);
      end
    end else begin
      if (state_q == ST_MDU_BUSY) begin
        mdu_done_c = 1'b1;
      end
      state_d = ST_RUN;
      if (redirect_ok_c) begin
        ctrl_c           = CTRL_REDIRECT;
        redirect_taken_c = 1'b1;
      end else if (bus.load_use) begin
        ctrl_c = CTRL_LOAD_USE;
      end
    end

    if (rst) begin
      ctrl_c           = CTRL_RESET;
      mdu_done_c       = 1'b0;
      redirect_taken_c = 1'b0;
    end
  end

  assign bus.pc_write     = ctrl_c.pc_write;
  assign bus.if_id_we     = ctrl_c.if_id_we;
  assign bus.id_ex_we     = ctrl_c.id_ex_we;
  assign bus.ex_mem_we    = ctrl_c.ex_mem_we;
  assign bus.mem_wb_we    = ctrl_c.mem_wb_we;
  assign bus.if_id_flush  = ctrl_c.if_id_flush;
  assign bus.id_ex_flush  = ctrl_c.id_ex_flush;
  assign bus.ex_mem_flush = ctrl_c.ex_mem_flush;
  assign bus.mdu_done     = mdu_done_c;
  assign bus.mem_timeout  = timeout_q;

  pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (~ctrl_c.pc_write),
    .cnt_o (bus.stall_cycles)
  );

  pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (redirect_taken_c),
    .cnt_o (bus.flush_events)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus randomized traffic,
// every cycle checked against a remaining-cycles model of the scheduler.
module tb_pipeline_stall_ctrl;

  localparam int unsigned MDU_LAT     = 4;
  localparam int unsigned MEM_TIMEOUT = 8;
  localparam int unsigned CNT_W       = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .MDU_LAT     (MDU_LAT),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: mdu_left = EX cycles still owed by the MDU op (including the done cycle).
  int               m_mdu_left;
  int               m_wait;
  bit               m_timeout;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;

  logic [7:0] o_ctrl;
  logic       o_done;
  logic       o_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [7:0] exp_ctrl;
    logic       exp_done;
    bit         memst;
    bit         redir;
    @(negedge clk);
    memst    = bus.mem_req && !bus.mem_ready;
    redir    = 1'b0;
    exp_done = 1'b0;
    if (rst) begin
      exp_ctrl = 8'h07;
    end else if (memst) begin
      exp_ctrl = 8'h00;
    end else if (m_mdu_left > 1 || (m_mdu_left == 0 && bus.mdu_start)) begin
      exp_ctrl = 8'h19;
    end else begin
      exp_done = (m_mdu_left == 1);
      if (bus.redirect && !exp_done) begin
        exp_ctrl = 8'hFE;
        redir    = 1'b1;
      end else if (bus.load_use) begin
        exp_ctrl = 8'h3A;
      end else begin
        exp_ctrl = 8'hF8;
      end
    end

    o_ctrl = {bus.pc_write, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we,
              bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
    o_done = bus.mdu_done;
    o_to   = bus.mem_timeout;
    chk("stage_ctrl", 64'(o_ctrl), 64'(exp_ctrl));
    chk("mdu_done", 64'(o_done), 64'(exp_done));
    if (!rst) begin
      chk("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
      chk("flush_events", 64'(bus.flush_events), 64'(m_flush));
      chk("mem_timeout", 64'(o_to), 64'(m_timeout));
    end

    if (rst) begin
      m_mdu_left = 0;
      m_wait     = 0;
      m_timeout  = 1'b0;
      m_stall    = '0;
      m_flush    = '0;
    end else begin
      if (!exp_ctrl[7]) m_stall = m_stall + CNT_W'(1);
      if (redir) m_flush = m_flush + CNT_W'(1);
      if (memst) begin
        if (m_wait < int'(MEM_TIMEOUT)) m_wait++;
        if (m_wait >= int'(MEM_TIMEOUT)) m_timeout = 1'b1;
      end else begin
        m_wait = 0;
        if (m_mdu_left > 0) m_mdu_left--;
        else if (bus.mdu_start) m_mdu_left = int'(MDU_LAT) - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.load_use  = 1'b0;
    bus.redirect  = 1'b0;
    bus.mdu_start = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n_stall;
    int n_frozen;
    int done_at;
    int to_at;

    idle();
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ctrl", 64'(o_ctrl), 64'h07);
    rst = 1'b0;
    step();
    chk("idle_ctrl", 64'(o_ctrl), 64'hF8);
    chk("idle_stall_cnt", 64'(bus.stall_cycles), 64'd0);

    // Single load-use bubble.
    bus.load_use = 1'b1;
    step();
    chk("lu_ctrl", 64'(o_ctrl), 64'h3A);
    bus.load_use = 1'b0;
    step();
    chk("lu_after", 64'(o_ctrl), 64'hF8);
    chk("lu_stall_cnt", 64'(bus.stall_cycles), 64'd1);

    // Redirect beats load-use.
    do_reset();
    bus.load_use = 1'b1;
    bus.redirect = 1'b1;
    step();
    chk("redir_lu_ctrl", 64'(o_ctrl), 64'hFE);
    idle();
    step();
    chk("redir_flush_cnt", 64'(bus.flush_events), 64'd1);
    chk("redir_stall_cnt", 64'(bus.stall_cycles), 64'd0);

    // Plain MDU op.
    do_reset();
    n_stall = 0;
    done_at = -1;
    for (int i = 0; i < 10; i++) begin
      bus.mdu_start = (i == 0);
      step();
      if (!o_ctrl[7]) n_stall++;
      if (o_done && done_at < 0) done_at = i + 1;
    end
    chk("mdu_stall_len", 64'(n_stall), 64'd3);
    chk("mdu_done_cycle", 64'(done_at), 64'd4);
    chk("mdu_stall_cnt", 64'(bus.stall_cycles), 64'd3);

    // MDU op stretched by a 5-cycle memory wait.
    do_reset();
    n_frozen = 0;
    done_at  = -1;
    for (int i = 0; i < 16; i++) begin
      bus.mdu_start = (i == 0);
      bus.mem_req   = (i >= 1 && i <= 5);
      bus.mem_ready = 1'b0;
      step();
      if (o_ctrl == 8'h00) n_frozen++;
      if (o_done && done_at < 0) done_at = i + 1;
    end
    chk("mdu_mem_frozen", 64'(n_frozen), 64'd5);
    chk("mdu_mem_done_cycle", 64'(done_at), 64'd9);
    chk("mdu_mem_no_timeout", 64'(o_to), 64'd0);

    // Memory timeout and its stickiness.
    do_reset();
    to_at = -1;
    for (int i = 0; i < 14; i++) begin
      bus.mem_req   = (i < 10);
      bus.mem_ready = 1'b0;
      step();
      if (o_to && to_at < 0) to_at = i;
    end
    chk("timeout_cycle", 64'(to_at), 64'd8);
    chk("timeout_sticky", 64'(o_to), 64'd1);
    do_reset();
    step();
    chk("timeout_cleared", 64'(o_to), 64'd0);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.load_use  = ($urandom_range(0, 4) == 0);
      bus.redirect  = ($urandom_range(0, 6) == 0);
      bus.mdu_start = ($urandom_range(0, 8) == 0);
      bus.mem_req   = ($urandom_range(0, 3) == 0) || ((i % 500) >= 480);
      bus.mem_ready = ((i % 500) >= 480) ? 1'b0 : ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
